// File: rtl/fifo_rd_stream.sv
// Read-side adapter for sync_fifo: turns the 1-cycle-latency rd_en/dout/empty
// interface into a valid/ready stream, tagging every PKT_LEN-th beat with m_last.
module fifo_rd_stream #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             err
);

    localparam int              BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(PKT_LEN - 1);

    logic [WIDTH-1:0] r_data [2];
    logic [1:0]       r_last;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_cnt;
    logic             r_inflight;
    logic [BW-1:0]    r_bcnt;
    logic             r_err;

    logic             w_pop;
    logic             w_drop;
    logic             w_cap;
    logic             w_bcnt_wrap;
    logic [2:0]       w_occ;

    always_comb begin
        w_pop       = (r_cnt != 2'd0) && m_ready;
        w_drop      = r_inflight && (r_cnt == 2'd2) && !w_pop;
        w_cap       = r_inflight && !w_drop;
        w_bcnt_wrap = (r_bcnt == LAST_BEAT);
        // Occupancy after this cycle counting the read already in flight;
        // only issue a new read if it is guaranteed a free slot on arrival.
        w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        fifo_rd_en  = rst_n && !fifo_empty && (w_occ < 3'd2);
    end

    assign m_valid = (r_cnt != 2'd0);
    assign m_data  = r_data[r_head];
    assign m_last  = r_last[r_head];
    assign err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '{default: '0};
            r_last     <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_bcnt     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_drop) begin
                r_err <= 1'b1;
            end
            if (w_cap) begin
                r_data[r_tail] <= fifo_dout;
                r_last[r_tail] <= w_bcnt_wrap;
                r_tail         <= ~r_tail;
                r_bcnt         <= w_bcnt_wrap ? '0 : r_bcnt + 1'b1;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, w_cap} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based sync_fifo model feeds the DUT,
// expected beats (data + packet tag) are queued at push time and popped by a monitor.
module tb_fifo_rd_stream;

    localparam int WIDTH   = 32;
    localparam int PKT_LEN = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             err;

    fifo_rd_stream #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .err        (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] src [$];
    logic [WIDTH:0]   exp_q [$];
    int               beat_idx = 0;
    int               rd_cnt = 0;
    int               pop_cnt = 0;
    int               cyc = 0;
    int               first_rd_cyc = -1;
    int               first_vld_cyc = -1;
    int               last_pop_cyc = -1;
    logic             hide = 1'b0;
    logic             prev_stall = 1'b0;
    logic [WIDTH:0]   prev_beat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty = hide || (src.size() == 0);
    endtask

    // Beats are numbered from reset; every PKT_LEN-th one closes a packet.
    task automatic push(input logic [WIDTH-1:0] d);
        src.push_back(d);
        exp_q.push_back({((beat_idx % PKT_LEN) == PKT_LEN - 1), d});
        beat_idx++;
        refresh();
    endtask

    task automatic tick(input logic rdy, input logic hd);
        @(posedge clk);
        #1;
        m_ready = rdy;
        hide    = hd;
        refresh();
    endtask

    // sync_fifo model: dout registered one cycle after rd_en.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && fifo_rd_en) begin
            if (src.size() != 0) fifo_dout <= src.pop_front();
            rd_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_empty) chk("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
            if (fifo_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (prev_stall) chk("hold_stable", {m_valid, m_last, m_data}, {1'b1, prev_beat});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_expected: got beat %0h with empty scoreboard (cycle %0d)", m_data, cyc);
                end else begin
                    chk("beat", {m_last, m_data}, exp_q.pop_front());
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int p0;
        int pushed;
        logic done;

        // Reset with a non-empty FIFO indication
        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        fifo_dout  = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        refresh();

        // Streaming 0..31
        p0 = pop_cnt;
        first_rd_cyc = -1;
        first_vld_cyc = -1;
        for (int i = 0; i < 32; i++) push(WIDTH'(i));
        for (int k = 0; k < 200 && pop_cnt - p0 < 32; k++) tick(1'b1, 1'b0);
        chk("stream_beats", 64'(pop_cnt - p0), 64'd32);
        chk("first_valid_latency", 64'(first_vld_cyc - first_rd_cyc), 64'd2);
        chk("stream_no_gaps", 64'(last_pop_cyc - first_vld_cyc), 64'd31);
        chk("stream_err", 64'(err), 64'd0);

        // Backpressure: 10-cycle stall after beat 5
        p0 = pop_cnt;
        done = 1'b0;
        for (int i = 0; i < 32; i++) push(WIDTH'(32'h100 + i));
        for (int k = 0; k < 300 && pop_cnt - p0 < 32; k++) begin
            if (!done && pop_cnt - p0 >= 5) begin
                for (int s = 0; s < 10; s++) begin
                    tick(1'b0, 1'b0);
                    if (s >= 2) begin
                        #2;
                        chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
                        chk("bp_buffered", 64'(rd_cnt - pop_cnt), 64'd2);
                        chk("bp_valid", 64'(m_valid), 64'd1);
                    end
                end
                done = 1'b1;
            end else begin
                tick(1'b1, 1'b0);
            end
        end
        chk("bp_beats", 64'(pop_cnt - p0), 64'd32);
        chk("bp_err", 64'(err), 64'd0);

        // Random ready and empty toggling over 200 words
        p0 = pop_cnt;
        pushed = 0;
        for (int k = 0; k < 3000 && pop_cnt - p0 < 200; k++) begin
            tick(1'($urandom % 2), 1'($urandom % 4 == 0));
            if (pushed < 200 && ($urandom % 3) != 0) begin
                push($urandom);
                pushed++;
            end
        end
        chk("rand_beats", 64'(pop_cnt - p0), 64'd200);
        chk("rand_err", 64'(err), 64'd0);

        // Single word then empty
        p0 = pop_cnt;
        push(32'hCAFE_0001);
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b0);
        chk("edge_beats", 64'(pop_cnt - p0), 64'd1);
        chk("edge_valid_low", 64'(m_valid), 64'd0);

        // Mid-stream reset with the buffer full
        for (int i = 0; i < 8; i++) push(WIDTH'(32'h200 + i));
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b0);
        chk("pre_reset_valid", 64'(m_valid), 64'd1);
        chk("pre_reset_buffered", 64'(rd_cnt - pop_cnt), 64'd2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_data", 64'(m_data), 64'd0);
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        src.delete();
        exp_q.delete();
        beat_idx = 0;
        rd_cnt   = 0;
        pop_cnt  = 0;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 16; i++) push(WIDTH'(32'h300 + i));
        for (int k = 0; k < 200 && pop_cnt - p0 < 16; k++) tick(1'b1, 1'b0);
        chk("post_rst_beats", 64'(pop_cnt - p0), 64'd16);
        chk("post_rst_err", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
